// File: rtl/srl_delay_ctl.sv
// Sequencer for an SRL64E variable delay line: slews the tap address one step per sample,
// tracks fill level for output validity, and zero-fills the line on request.
module srl_delay_ctl #(
  parameter int unsigned AW    = 6,
  parameter int unsigned FLUSH = 2 ** AW
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_stb,
  input  logic          i_dly_req,
  input  logic [AW-1:0] i_dly,
  output logic          o_dly_ack,
  input  logic          i_flush,
  output logic [AW-1:0] o_a,
  output logic          o_ce,
  output logic          o_zd,
  output logic          o_vld,
  output logic          o_busy,
  output logic          o_drop
);

  localparam logic [AW:0]   DepthW   = (AW + 1)'(2 ** AW);
  localparam logic [AW-1:0] FlushTop = AW'(FLUSH - 1);

  typedef enum logic [1:0] {StIdle, StSlew, StFlsh} state_e;

  state_e        r_state, w_state_d;
  logic [AW-1:0] r_cur, w_cur_d;
  logic [AW-1:0] r_tgt, w_tgt_d;
  logic [AW:0]   r_fill, w_fill_d;
  logic [AW-1:0] r_cnt, w_cnt_d;
  logic          r_ack, w_ack_d;
  logic          r_vld, w_vld_d;
  logic          r_drop, w_drop_d;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= StIdle;
      r_cur   <= '0;
      r_tgt   <= '0;
      r_fill  <= '0;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_vld   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cur   <= w_cur_d;
      r_tgt   <= w_tgt_d;
      r_fill  <= w_fill_d;
      r_cnt   <= w_cnt_d;
      r_ack   <= w_ack_d;
      r_vld   <= w_vld_d;
      r_drop  <= w_drop_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cur_d   = r_cur;
    w_tgt_d   = r_tgt;
    w_fill_d  = r_fill;
    w_cnt_d   = r_cnt;
    w_ack_d   = 1'b0;
    w_vld_d   = 1'b0;
    w_drop_d  = 1'b0;
    o_ce      = 1'b0;
    o_zd      = 1'b0;
    unique case (r_state)
      StFlsh: begin
        o_ce     = 1'b1;
        o_zd     = 1'b1;
        w_drop_d = i_stb;
        if (i_flush) begin
          w_cnt_d = FlushTop;
        end else if (r_cnt == '0) begin
          // Line is all zeros now, so any tap is valid: jump straight to the target.
          w_cur_d   = r_tgt;
          w_fill_d  = DepthW;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      default: begin
        if (i_flush) begin
          w_drop_d  = i_stb;
          w_cnt_d   = FlushTop;
          w_state_d = StFlsh;
        end else begin
          o_ce = i_stb;
          // The cycle ACK is shown the requester still holds REQ; do not accept it twice.
          w_ack_d = i_dly_req & ~r_ack;
          if (i_stb) begin
            if (r_cur < r_tgt) begin
              w_cur_d = r_cur + 1'b1;
            end else if (r_cur > r_tgt) begin
              w_cur_d = r_cur - 1'b1;
            end
            w_fill_d = (r_fill == DepthW) ? r_fill : r_fill + 1'b1;
            w_vld_d  = (w_fill_d > {1'b0, w_cur_d});
          end
          if (w_ack_d) begin
            w_tgt_d = i_dly;
          end
          w_state_d = (w_cur_d == w_tgt_d) ? StIdle : StSlew;
        end
      end
    endcase
  end

  assign o_a       = r_cur;
  assign o_dly_ack = r_ack;
  assign o_vld     = r_vld;
  assign o_drop    = r_drop;
  assign o_busy    = (r_state != StIdle);

endmodule

// File: tb/tb_srl_delay_ctl.sv
// Scoreboard bench for srl_delay_ctl: an integer-level model predicts every cycle's outputs,
// a monitor process compares them and the directed scenario checks.
module tb_srl_delay_ctl;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int FL    = 64;

  logic          clk = 1'b0;
  logic          rstn, stb, req, flush;
  logic [AW-1:0] dly;
  logic          o_ack, o_ce, o_zd, o_vld, o_busy, o_drop;
  logic [AW-1:0] o_a;

  always #5 clk = ~clk;

  srl_delay_ctl #(.AW(AW), .FLUSH(FL)) dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_stb    (stb),
    .i_dly_req(req),
    .i_dly    (dly),
    .o_dly_ack(o_ack),
    .i_flush  (flush),
    .o_a      (o_a),
    .o_ce     (o_ce),
    .o_zd     (o_zd),
    .o_vld    (o_vld),
    .o_busy   (o_busy),
    .o_drop   (o_drop)
  );

  typedef logic [11:0] vec_t;
  typedef struct {
    string nm;
    int    act;
    int    exp;
  } dchk_t;

  vec_t  exp_q[$];
  dchk_t dq[$];
  int    total = 0;
  int    bad = 0;
  int    cyc_n = 0;

  // Reference model state
  int m_cur = 0, m_tgt = 0, m_fill = 0, m_fl = 0;
  bit m_vld = 0, m_drop = 0, m_ack = 0;

  bit            req_active = 0;
  logic [AW-1:0] req_dly = '0;
  logic          l_ack, l_ce, l_zd, l_vld, l_busy, l_drop;
  logic [AW-1:0] l_a;

  // Monitor: all comparisons happen here
  always @(negedge clk) begin
    vec_t  got, want;
    dchk_t d;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {o_ack, o_a, o_ce, o_zd, o_vld, o_busy, o_drop};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL outputs cyc=%0d got ack/a/ce/zd/vld/busy/drop=%b/%0d/%b/%b/%b/%b/%b want=%b/%0d/%b/%b/%b/%b/%b",
                 cyc_n, got[11], got[10:5], got[4], got[3], got[2], got[1], got[0],
                 want[11], want[10:5], want[4], want[3], want[2], want[1], want[0]);
      end
    end
    while (dq.size() > 0) begin
      d = dq.pop_front();
      total++;
      if (d.act != d.exp) begin
        bad++;
        $display("FAIL %s got=%0d want=%0d", d.nm, d.act, d.exp);
      end
    end
  end

  function automatic vec_t model_out(input bit s, input bit f);
    bit fl, ce, busy;
    logic [AW-1:0] a;
    fl   = (m_fl > 0);
    ce   = fl ? 1'b1 : (s && !f);
    busy = fl || (m_cur != m_tgt);
    a    = AW'(m_cur);
    return {m_ack, a, ce, fl, m_vld, busy, m_drop};
  endfunction

  task automatic model_step(input bit r, input bit s, input bit q, input bit f, input int d);
    bit fl, nack, ndrop, nvld;
    if (!r) begin
      m_cur = 0; m_tgt = 0; m_fill = 0; m_fl = 0;
      m_vld = 0; m_drop = 0; m_ack = 0;
      return;
    end
    fl    = (m_fl > 0);
    nack  = q && !m_ack && !fl && !f;
    ndrop = s && (fl || f);
    nvld  = 0;
    if (f) begin
      m_fl = FL;
    end else if (fl) begin
      m_fl--;
      if (m_fl == 0) begin
        m_cur  = m_tgt;
        m_fill = DEPTH;
      end
    end else begin
      if (s) begin
        if (m_cur < m_tgt) m_cur++;
        else if (m_cur > m_tgt) m_cur--;
        m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
        nvld   = (m_fill >= m_cur + 1);
      end
      if (nack) m_tgt = d;
    end
    m_ack  = nack;
    m_drop = ndrop;
    m_vld  = nvld;
  endtask

  // One clock cycle: drive, predict, let the monitor compare, latch observed outputs.
  task automatic cyc(input bit s, input bit f, input bit r = 1'b1);
    bit was_ack;
    rstn  = r;
    stb   = s;
    flush = f;
    req   = req_active;
    dly   = req_dly;
    exp_q.push_back(model_out(s, f));
    was_ack = m_ack;
    model_step(r, s, req_active, f, int'(req_dly));
    if (was_ack) req_active = 0;
    @(negedge clk);
    l_ack = o_ack; l_a = o_a; l_ce = o_ce; l_zd = o_zd;
    l_vld = o_vld; l_busy = o_busy; l_drop = o_drop;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic request(input int d);
    req_active = 1;
    req_dly    = AW'(d);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    dchk_t d;
    d.nm = nm; d.act = act; d.exp = exp;
    dq.push_back(d);
  endtask

  initial begin
    int n_ce, n_drop, n_ack, n_busy, last_zd, ack_at, a12, b11, b12;
    rstn = 0; stb = 0; req = 0; flush = 0; dly = '0;
    @(posedge clk);
    #1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst_a", int'(l_a), 0);
    chk("rst_busy", int'(l_busy), 0);
    chk("rst_vld", int'(l_vld), 0);

    // Delay 5, then 10 samples
    request(5);
    cyc(0, 0);
    cyc(0, 0);
    chk("ack_latency", int'(l_ack), 1);
    for (int k = 1; k <= 10; k++) begin
      cyc(1, 0);
      cyc(0, 0);
      chk($sformatf("a_after_stb%0d", k), int'(l_a), (k < 5) ? k : 5);
      chk($sformatf("vld_after_stb%0d", k), int'(l_vld), (k >= 6) ? 1 : 0);
    end

    // Slew down 5 -> 2 with a sample every 4 cycles
    request(2);
    n_ack = 0; n_drop = 0; n_busy = 0; a12 = -1; b11 = -1; b12 = -1;
    for (int i = 0; i <= 13; i++) begin
      cyc((i % 4) == 3, 0);
      n_ack  += int'(l_ack);
      n_drop += int'(l_drop);
      n_busy += int'(l_busy);
      if (i == 11) b11 = int'(l_busy);
      if (i == 12) begin a12 = int'(l_a); b12 = int'(l_busy); end
    end
    chk("slew_acks", n_ack, 1);
    chk("slew_drops", n_drop, 0);
    chk("slew_busy_cycles", n_busy, 11);
    chk("slew_busy_last", b11, 1);
    chk("slew_a_done", a12, 2);
    chk("slew_idle_done", b12, 0);

    // CUR=3, TGT=40, then flush
    request(3);
    cyc(0, 0);
    cyc(1, 0);
    request(40);
    cyc(0, 0);
    cyc(0, 0);
    chk("pre_flush_a", int'(l_a), 3);
    n_ce = 0;
    cyc(0, 1);
    n_ce += int'(l_ce && l_zd);
    for (int i = 0; i < 70; i++) begin
      cyc(0, 0);
      n_ce += int'(l_ce && l_zd);
    end
    chk("flush_ce_cycles", n_ce, 64);
    chk("flush_a_tgt", int'(l_a), 40);
    chk("flush_busy_end", int'(l_busy), 0);
    cyc(1, 0);
    cyc(0, 0);
    chk("post_flush_vld", int'(l_vld), 1);

    // STB with FLUSH and STB mid-flush
    n_ce = 0; n_drop = 0;
    for (int i = 0; i <= 70; i++) begin
      cyc((i == 0) || (i == 10), i == 0);
      n_ce   += int'(l_ce);
      n_drop += int'(l_drop);
    end
    chk("drop_flush_ce", n_ce, 64);
    chk("drop_count", n_drop, 2);

    // Request held across a flush
    request(17);
    last_zd = -1; ack_at = -1;
    for (int i = 0; i <= 72; i++) begin
      cyc(0, i == 0);
      if (l_zd) last_zd = i;
      if (l_ack && ack_at < 0) ack_at = i;
    end
    chk("held_ack_after_exit", ack_at - last_zd, 2);
    chk("held_busy", int'(l_busy), 1);
    cyc(1, 0);
    cyc(0, 0);
    chk("held_tgt_step", int'(l_a), 39);

    // Reset mid-slew
    cyc(1, 0);
    cyc(0, 0, 0);
    cyc(0, 0);
    chk("rst_slew_a", int'(l_a), 0);
    chk("rst_slew_busy", int'(l_busy), 0);
    chk("rst_slew_ce", int'(l_ce), 0);

    // Reset mid-flush
    cyc(0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0);
    chk("mid_flush_zd", int'(l_zd), 1);
    cyc(0, 0, 0);
    cyc(0, 0);
    chk("rst_flush_ce", int'(l_ce), 0);
    chk("rst_flush_zd", int'(l_zd), 0);
    chk("rst_flush_busy", int'(l_busy), 0);
    chk("rst_flush_a", int'(l_a), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (!req_active && ($urandom % 20) == 0) request(int'($urandom % DEPTH));
      cyc(($urandom % 3) == 0, ($urandom % 150) == 0, ($urandom % 800) != 0);
    end

    for (int i = 0; i < 5 && (exp_q.size() > 0 || dq.size() > 0); i++) @(negedge clk);
    if (exp_q.size() > 0 || dq.size() > 0) begin
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size() + dq.size());
      $fatal(1);
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
